// File: rtl/radix_divider_if.sv
// Start/ready/done request-response bundle for radix_divider.
interface radix_divider_if #(
    parameter int DIV_WIDTH = 32
);
    logic                 start;
    logic                 sign;
    logic [DIV_WIDTH-1:0] in1;
    logic [DIV_WIDTH-1:0] in2;
    logic                 ready;
    logic                 done;
    logic [DIV_WIDTH-1:0] q;
    logic [DIV_WIDTH-1:0] r;
    logic                 dz;

    modport master (output start, sign, in1, in2, input ready, done, q, r, dz);
    modport slave  (input start, sign, in1, in2, output ready, done, q, r, dz);
endinterface

// File: rtl/radix_divider.sv
// Fixed-latency restoring divider retiring BITS_PER_CYCLE quotient bits per
// clock. Signed mode divides magnitudes and fixes signs in a final FIX state;
// divide-by-zero and signed overflow bypass the iterations entirely.

// One restoring shift-subtract sub-step. The dividend register doubles as the
// quotient register: its msb is consumed and the new quotient bit enters at
// the lsb.
module radix_divider_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_dvd,
    input  logic [W:0]   i_dvs,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_dvd
);
    logic [W:0]   w_shift;
    logic [W-1:0] w_sub;
    logic         w_ge;

    assign w_shift = {i_rem, i_dvd[W-1]};
    assign w_ge    = (w_shift >= i_dvs);
    // When the trial succeeds the difference is below the divisor, so the low
    // W bits carry it exactly.
    assign w_sub   = w_shift[W-1:0] - i_dvs[W-1:0];
    assign o_rem   = w_ge ? w_sub : w_shift[W-1:0];
    assign o_dvd   = {i_dvd[W-2:0], w_ge};
endmodule

module radix_divider #(
    parameter int DIV_WIDTH      = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    radix_divider_if.slave bus
);
    localparam int W  = DIV_WIDTH;
    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = W / B;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W:0]    r_dvs;
    logic          r_qneg;
    logic          r_rneg;
    logic          r_dzp;
    logic          r_done;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_r;
    logic          r_dz;

    logic          w_neg1;
    logic          w_neg2;
    logic [W-1:0]  w_mag1;
    logic [W:0]    w_mag2;
    logic          w_dz;
    logic          w_ovf;

    logic [B:0][W-1:0] w_rem_c;
    logic [B:0][W-1:0] w_dvd_c;

    // Operand conditioning at acceptance. The sign terms are zero in unsigned
    // mode, so the mode itself needs no register. The dividend magnitude fits
    // W unsigned bits (2^(W-1) included); the divisor is kept W+1 wide.
    assign w_neg1 = bus.sign & bus.in1[W-1];
    assign w_neg2 = bus.sign & bus.in2[W-1];
    assign w_mag1 = w_neg1 ? (~bus.in1 + 1'b1) : bus.in1;
    assign w_mag2 = {1'b0, (w_neg2 ? (~bus.in2 + 1'b1) : bus.in2)};
    assign w_dz   = (bus.in2 == '0);
    assign w_ovf  = bus.sign & (bus.in1 == {1'b1, {(W-1){1'b0}}}) & (bus.in2 == '1);

    // Chain B sub-steps combinationally within one RUN cycle.
    assign w_rem_c[0] = r_rem;
    assign w_dvd_c[0] = r_quo;
    for (genvar i = 0; i < B; i++) begin : g_step
        radix_divider_step #(.W(W)) u_step (
            .i_rem (w_rem_c[i]),
            .i_dvd (w_dvd_c[i]),
            .i_dvs (r_dvs),
            .o_rem (w_rem_c[i+1]),
            .o_dvd (w_dvd_c[i+1])
        );
    end

    // Control FSM, iteration datapath and result registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dzp   <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cnt <= '0;
                        if (w_dz) begin
                            // Result is final already; FIX passes it through.
                            r_quo   <= '1;
                            r_rem   <= bus.in1;
                            r_qneg  <= 1'b0;
                            r_rneg  <= 1'b0;
                            r_dzp   <= 1'b1;
                            r_state <= S_FIX;
                        end else if (w_ovf) begin
                            r_quo   <= bus.in1;
                            r_rem   <= '0;
                            r_qneg  <= 1'b0;
                            r_rneg  <= 1'b0;
                            r_dzp   <= 1'b0;
                            r_state <= S_FIX;
                        end else begin
                            r_quo   <= w_mag1;
                            r_rem   <= '0;
                            r_dvs   <= w_mag2;
                            r_qneg  <= w_neg1 ^ w_neg2;
                            r_rneg  <= w_neg1;
                            r_dzp   <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_c[B];
                    r_quo <= w_dvd_c[B];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_q     <= r_qneg ? (~r_quo + 1'b1) : r_quo;
                    r_r     <= r_rneg ? (~r_rem + 1'b1) : r_rem;
                    r_dz    <= r_dzp;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready = (r_state == S_IDLE);
    assign bus.done  = r_done;
    assign bus.q     = r_q;
    assign bus.r     = r_r;
    assign bus.dz    = r_dz;
endmodule

// File: tb/tb_radix_divider.sv
// Scoreboard bench for radix_divider over four width/radix configurations.
module tb_radix_divider;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NI-1:0] t_start, t_sign, t_ready, t_done, t_dz;
    logic [31:0]   t_in1 [NI];
    logic [31:0]   t_in2 [NI];
    logic [31:0]   t_q   [NI];
    logic [31:0]   t_r   [NI];

    // inst0 W32/B1, inst1 W32/B4, inst2 W8/B2, inst3 W8/B4
    function automatic int wof(int k); return (k < 2) ? 32 : 8; endfunction
    function automatic int bof(int k); return (k == 0) ? 1 : (k == 2) ? 2 : 4; endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g < 2) ? 32 : 8;
        localparam int B = (g == 0) ? 1 : (g == 2) ? 2 : 4;
        radix_divider_if #(.DIV_WIDTH(W)) bus ();
        assign bus.start  = t_start[g];
        assign bus.sign   = t_sign[g];
        assign bus.in1    = t_in1[g][W-1:0];
        assign bus.in2    = t_in2[g][W-1:0];
        assign t_ready[g] = bus.ready;
        assign t_done[g]  = bus.done;
        assign t_dz[g]    = bus.dz;
        assign t_q[g]     = 32'(bus.q);
        assign t_r[g]     = 32'(bus.r);
        radix_divider #(.DIV_WIDTH(W), .BITS_PER_CYCLE(B)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus.slave)
        );
    end

    typedef struct {
        int          id;
        int          acc;
        int          lat;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    typedef struct {
        int          k;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: 64-bit host arithmetic, truncating division.
    function automatic exp_t model(int k, logic sg, logic [31:0] a, logic [31:0] b, int acc);
        exp_t   e;
        int     w;
        longint mask, ua, ub, sa, sd, qq, rr;
        w     = wof(k);
        mask  = (longint'(1) << w) - 1;
        ua    = longint'(a) & mask;
        ub    = longint'(b) & mask;
        e.id  = k;
        e.acc = acc;
        e.lat = wof(k) / bof(k) + 2;
        e.dz  = 1'b0;
        if (ub == 0) begin
            qq = mask; rr = ua; e.dz = 1'b1; e.lat = 2;
        end else if (!sg) begin
            qq = ua / ub; rr = ua % ub;
        end else begin
            sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
            sd = ub[w-1] ? ub - (longint'(1) << w) : ub;
            qq = sa / sd; rr = sa % sd;
            if (sa == -(longint'(1) << (w - 1)) && sd == -1) e.lat = 2;
        end
        e.q = 32'(qq & mask);
        e.r = 32'(rr & mask);
        return e;
    endfunction

    function automatic int pending(int k);
        int n = 0;
        foreach (sb[i]) if (sb[i].id == k) n++;
        return n;
    endfunction

    task automatic flush(int k);
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].id == k) sb.delete(i);
    endtask

    // One clock for instance k: predict acceptance, step, then check any done.
    task automatic cycle(int k);
        exp_t e;
        int   idx;
        if (t_start[k] && t_ready[k] && rst_n)
            sb.push_back(model(k, t_sign[k], t_in1[k], t_in2[k], edge_cnt + 1));
        @(posedge clk);
        @(negedge clk);
        if (t_done[k]) begin
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].id == k) idx = i;
            n_chk++;
            if (idx < 0) begin
                n_fail++;
                $display("FAIL done_unexpected inst%0d: done=1, expected no outstanding result", k);
            end else begin
                e = sb[idx];
                sb.delete(idx);
                n_chk++;
                if (t_q[k] !== e.q) begin
                    n_fail++;
                    $display("FAIL sb_q inst%0d: got %h expected %h", k, t_q[k], e.q);
                end
                n_chk++;
                if (t_r[k] !== e.r) begin
                    n_fail++;
                    $display("FAIL sb_r inst%0d: got %h expected %h", k, t_r[k], e.r);
                end
                n_chk++;
                if (t_dz[k] !== e.dz) begin
                    n_fail++;
                    $display("FAIL sb_dz inst%0d: got %b expected %b", k, t_dz[k], e.dz);
                end
                n_chk++;
                if ((edge_cnt + 1 - e.acc) != e.lat) begin
                    n_fail++;
                    $display("FAIL sb_latency inst%0d: got %0d expected %0d", k, edge_cnt + 1 - e.acc, e.lat);
                end
            end
        end
    endtask

    task automatic run_op(int k, logic sg, logic [31:0] a, logic [31:0] b);
        int guard;
        t_sign[k] = sg; t_in1[k] = a; t_in2[k] = b; t_start[k] = 1'b1;
        cycle(k);
        t_start[k] = 1'b0;
        guard = 0;
        while (pending(k) > 0 && guard < 80) begin
            cycle(k);
            guard++;
        end
        if (pending(k) > 0) begin
            n_chk++; n_fail++;
            $display("FAIL timeout inst%0d: no done within 80 cycles", k);
            flush(k);
        end
    endtask

    function automatic logic [31:0] pick(int w);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return m;
            2:       return 32'd1 << (w - 1);
            3:       return 32'($urandom_range(1, 3));
            4:       return m - 32'($urandom_range(1, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        t_start = '0; t_sign = '0;
        for (int k = 0; k < NI; k++) begin t_in1[k] = 32'd9; t_in2[k] = 32'd3; end
        t_start[0] = 1'b1;   // must lose against reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (t_ready[k] !== 1'b1 || t_done[k] !== 1'b0 || t_q[k] !== 32'd0 ||
                t_r[k] !== 32'd0 || t_dz[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: ready=%b done=%b q=%h r=%h dz=%b expected 1 0 0 0 0",
                         k, t_ready[k], t_done[k], t_q[k], t_r[k], t_dz[k]);
            end
        end
        t_start[0] = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        vec_t tv [4];
        tv[0] = '{0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        tv[1] = '{1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        tv[2] = '{0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0};
        tv[3] = '{2, 1'b0, 32'd200, 32'd7, 32'd28, 32'd4, 1'b0};
        foreach (tv[i]) begin
            run_op(tv[i].k, tv[i].sg, tv[i].a, tv[i].b);
            n_chk++;
            if (t_q[tv[i].k] !== tv[i].q || t_r[tv[i].k] !== tv[i].r || t_dz[tv[i].k] !== tv[i].dz) begin
                n_fail++;
                $display("FAIL unsigned[%0d]: q=%h r=%h dz=%b expected q=%h r=%h dz=%b", i,
                         t_q[tv[i].k], t_r[tv[i].k], t_dz[tv[i].k], tv[i].q, tv[i].r, tv[i].dz);
            end
        end
    endtask

    task automatic test_signed();
        vec_t tv [5];
        tv[0] = '{0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        tv[1] = '{0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0};
        tv[2] = '{0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0};
        tv[3] = '{1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        tv[4] = '{3, 1'b1, 32'h0000_00F9, 32'd2, 32'h0000_00FD, 32'h0000_00FF, 1'b0};
        foreach (tv[i]) begin
            run_op(tv[i].k, tv[i].sg, tv[i].a, tv[i].b);
            n_chk++;
            if (t_q[tv[i].k] !== tv[i].q || t_r[tv[i].k] !== tv[i].r || t_dz[tv[i].k] !== tv[i].dz) begin
                n_fail++;
                $display("FAIL signed[%0d]: q=%h r=%h dz=%b expected q=%h r=%h dz=%b", i,
                         t_q[tv[i].k], t_r[tv[i].k], t_dz[tv[i].k], tv[i].q, tv[i].r, tv[i].dz);
            end
        end
    endtask

    task automatic test_special();
        vec_t tv [6];
        tv[0] = '{0, 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1};
        tv[1] = '{0, 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1};
        tv[2] = '{0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
        tv[3] = '{0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
        tv[4] = '{2, 1'b1, 32'h0000_0080, 32'h0000_00FF, 32'h0000_0080, 32'd0, 1'b0};
        tv[5] = '{2, 1'b1, 32'h0000_00F0, 32'd0, 32'h0000_00FF, 32'h0000_00F0, 1'b1};
        foreach (tv[i]) begin
            run_op(tv[i].k, tv[i].sg, tv[i].a, tv[i].b);
            n_chk++;
            if (t_q[tv[i].k] !== tv[i].q || t_r[tv[i].k] !== tv[i].r || t_dz[tv[i].k] !== tv[i].dz) begin
                n_fail++;
                $display("FAIL special[%0d]: q=%h r=%h dz=%b expected q=%h r=%h dz=%b", i,
                         t_q[tv[i].k], t_r[tv[i].k], t_dz[tv[i].k], tv[i].q, tv[i].r, tv[i].dz);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        int prev;
        nb = wof(1) / bof(1) + 2;
        prev = -1;
        t_start[1] = 1'b1;
        for (int c = 0; c < 5 * nb; c++) begin
            t_sign[1] = 1'($urandom_range(0, 1));
            t_in1[1]  = $urandom;
            t_in2[1]  = ($urandom & 32'h7FFF_FFFF) | 32'd2;
            if (t_ready[1]) begin
                if (prev >= 0) begin
                    n_chk++;
                    if ((edge_cnt + 1 - prev) != nb) begin
                        n_fail++;
                        $display("FAIL b2b_gap: got %0d expected %0d", edge_cnt + 1 - prev, nb);
                    end
                end
                prev = edge_cnt + 1;
            end
            cycle(1);
        end
        t_start[1] = 1'b0;
        for (int c = 0; c < 40 && pending(1) > 0; c++) cycle(1);
        n_chk++;
        if (pending(1) != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d results outstanding, expected 0", pending(1));
            flush(1);
        end
    endtask

    task automatic test_ignore_busy();
        t_sign[0] = 1'b0; t_in1[0] = 32'd1000; t_in2[0] = 32'd10; t_start[0] = 1'b1;
        cycle(0);
        t_start[0] = 1'b0;
        for (int c = 0; c < 40 && pending(0) > 0; c++) begin
            t_start[0] = (c >= 3 && c <= 6);
            if (c == 3) begin t_in1[0] = 32'd5; t_in2[0] = 32'd5; end
            cycle(0);
            if (c >= 3 && c <= 6) begin
                n_chk++;
                if (t_ready[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_ready: got %b expected 0 (cycle %0d)", t_ready[0], c);
                end
            end
        end
        t_start[0] = 1'b0;
        n_chk++;
        if (pending(0) != 0) begin
            n_fail++;
            $display("FAIL busy_timeout: %0d outstanding, expected 0", pending(0));
            flush(0);
        end
        repeat (3) cycle(0);
        n_chk++;
        if (t_q[0] !== 32'd100 || t_r[0] !== 32'd0 || t_dz[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_hold: q=%h r=%h dz=%b expected q=64 r=0 dz=0", t_q[0], t_r[0], t_dz[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        t_sign[0] = 1'b0; t_in1[0] = 32'd1000; t_in2[0] = 32'd7; t_start[0] = 1'b1;
        cycle(0);
        t_start[0] = 1'b0;
        repeat (9) cycle(0);
        flush(0);
        rst_n = 1'b0;
        cycle(0);
        n_chk++;
        if (t_done[0] !== 1'b0 || t_q[0] !== 32'd0 || t_r[0] !== 32'd0 || t_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: done=%b q=%h r=%h ready=%b expected 0 0 0 1",
                     t_done[0], t_q[0], t_r[0], t_ready[0]);
        end
        rst_n = 1'b1;
        repeat (40) cycle(0);
        run_op(0, 1'b0, 32'd9, 32'd3);
        n_chk++;
        if (t_q[0] !== 32'd3 || t_r[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset: q=%h r=%h expected q=3 r=0", t_q[0], t_r[0]);
        end
    endtask

    task automatic rand_run(int k, int n);
        for (int i = 0; i < n; i++)
            run_op(k, 1'($urandom_range(0, 1)), pick(wof(k)), pick(wof(k)));
    endtask

    task automatic test_random();
        fork
            rand_run(0, 600);
            rand_run(1, 2000);
            rand_run(2, 3400);
            rand_run(3, 4000);
        join
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
